pipe_stage_reg: RTL

- Parametrised pipeline stage register with a two-entry skid buffer.
- Successor to the fixed ID/EX-style stage registers: replaces the hard-coded PC, instruction and register-index fields with one generic payload of width `WIDTH`.
- Uses valid/ready handshakes on both sides, plus `flush` (kill), `hold` (freeze) and `bubble` (refuse upstream) controls, and a saturating bubble-cycle counter for performance monitoring.
- Sits between any two core pipeline stages (IF/ID, ID/EX, EX/MEM).

---
 rtl/pipe_pkg.sv | 15 +
 rtl/sat_counter.sv | 24 ++
 rtl/pipe_stage_reg.sv | 105 ++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for pipeline stage registers.
// The state encoding and occupancy codes are used by the stage register and its bench.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_e;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
// Reusable for any performance-monitoring event count.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with a two-entry skid buffer, flush/hold/bubble
// controls and a saturating bubble-cycle counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = '0,
  parameter int unsigned      CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  input  logic             hold,
  input  logic             bubble,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] bubble_cnt
);

  pipe_state_e      state_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic [1:0]       occ_q;
  logic             in_fire;
  logic             out_fire;

  // in_ready looks only at state and controls, never at out_ready, so the
  // skid entry is what absorbs a downstream stall.
  assign in_ready  = !flush && !hold && !bubble && (state_q != SKID);
  assign out_valid = !flush && !hold && (state_q != EMPTY);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would let main_q see a freshly written skid_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= BUBBLE_VAL;
      skid_q  <= BUBBLE_VAL;
      occ_q   <= OCC_EMPTY;
    end else if (flush) begin
      state_q <= EMPTY;
      main_q  <= BUBBLE_VAL;
      skid_q  <= BUBBLE_VAL;
      occ_q   <= OCC_EMPTY;
    end else if (!hold) begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_q <= FULL;
            main_q  <= in_data;
            occ_q   <= OCC_ONE;
          end
        end
        FULL: begin
          if (in_fire && out_fire) begin
            main_q <= in_data;
          end else if (out_fire) begin
            state_q <= EMPTY;
            main_q  <= BUBBLE_VAL;
            occ_q   <= OCC_EMPTY;
          end else if (in_fire) begin
            state_q <= SKID;
            skid_q  <= in_data;
            occ_q   <= OCC_TWO;
          end
        end
        SKID: begin
          // main always holds the oldest entry, so the skid entry moves up.
          if (out_fire) begin
            state_q <= FULL;
            main_q  <= skid_q;
            skid_q  <= BUBBLE_VAL;
            occ_q   <= OCC_ONE;
          end
        end
        default: begin
          state_q <= EMPTY;
          main_q  <= BUBBLE_VAL;
          skid_q  <= BUBBLE_VAL;
          occ_q   <= OCC_EMPTY;
        end
      endcase
    end
  end

  assign out_data  = main_q;
  assign occupancy = occ_q;

  sat_counter #(
    .W (CNT_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bubble && !flush && !hold),
    .count (bubble_cnt)
  );

endmodule
